// File: rtl/lz4_token_fifo_arb_if.sv
// Token handshake and FIFO write-port bundle between two LZ4 engines, the arbiter and the token FIFO.
// slave is the arbiter's view; master is the environment (engines plus FIFO) driving it.
interface lz4_token_fifo_arb_if #(
    parameter int TOK_W = 47,
    parameter int CNT_W = 10
);
    logic [TOK_W-1:0] src0_din;
    logic             src0_valid;
    logic             src0_ready;
    logic [TOK_W-1:0] src1_din;
    logic             src1_valid;
    logic             src1_ready;
    logic [TOK_W-1:0] fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_data_count;

    modport slave (
        input  src0_din, src0_valid, src1_din, src1_valid, fifo_full, fifo_data_count,
        output src0_ready, src1_ready, fifo_din, fifo_wr_en
    );

    modport master (
        output src0_din, src0_valid, src1_din, src1_valid, fifo_full, fifo_data_count,
        input  src0_ready, src1_ready, fifo_din, fifo_wr_en
    );
endinterface

// File: rtl/lz4_token_fifo_arb.sv
// Round-robin whole-block arbiter for the shared LZ4 token FIFO write port; accept-to-write is 1 cycle.
// Owner's ready follows FIFO space (counting the in-flight write); the non-owner is held off.
module lz4_token_fifo_arb #(
    parameter int TOK_W      = 47,
    parameter int FIFO_DEPTH = 512,
    parameter int CNT_W      = 10,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lz4_token_fifo_arb_if.slave  bus,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_cnt0,
    output logic [BLK_CNT_W-1:0] blk_cnt1
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [CNT_W:0] SPACE_LIMIT = (CNT_W+1)'(FIFO_DEPTH - 2);

    state_t         state;
    logic           last_owner;
    logic [CNT_W:0] fill_sum;
    logic           space_ok;
    logic           acc0;
    logic           acc1;
    logic           last0;
    logic           last1;

    always_comb begin
        fill_sum = {1'b0, bus.fifo_data_count} + {{CNT_W{1'b0}}, bus.fifo_wr_en};
        space_ok = !bus.fifo_full && (fill_sum <= SPACE_LIMIT);
    end

    // Gated by rst so nothing is accepted while reset is held, whatever the state was.
    assign bus.src0_ready = !rst && (state == OWN0) && space_ok;
    assign bus.src1_ready = !rst && (state == OWN1) && space_ok;

    assign acc0  = bus.src0_valid && bus.src0_ready;
    assign acc1  = bus.src1_valid && bus.src1_ready;
    assign last0 = bus.src0_din[TOK_W-1];
    assign last1 = bus.src1_din[TOK_W-1];
    assign busy  = (grant != 2'b00) || bus.fifo_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= 2'b00;
            last_owner     <= 1'b1;
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din   <= '0;
            blk_cnt0       <= '0;
            blk_cnt1       <= '0;
        end else begin
            bus.fifo_wr_en <= acc0 || acc1;
            if (acc0) begin
                bus.fifo_din <= bus.src0_din;
            end else if (acc1) begin
                bus.fifo_din <= bus.src1_din;
            end

            case (state)
                IDLE: begin
                    if (bus.src0_valid && (!bus.src1_valid || last_owner)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (bus.src1_valid) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (acc0 && last0) begin
                        blk_cnt0   <= blk_cnt0 + BLK_CNT_W'(1);
                        last_owner <= 1'b0;
                        // Hand straight over to a waiting peer so back-to-back blocks need no bubble.
                        if (bus.src1_valid) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (acc1 && last1) begin
                        blk_cnt1   <= blk_cnt1 + BLK_CNT_W'(1);
                        last_owner <= 1'b1;
                        if (bus.src0_valid) begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lz4_token_fifo_arb.sv
// Directed scenarios plus a randomized soak, checked against a block-level scoreboard of the token FIFO.
module tb_lz4_token_fifo_arb;
    localparam int TOK_W      = 47;
    localparam int FIFO_DEPTH = 512;
    localparam int CNT_W      = 10;
    localparam int BLK_CNT_W  = 16;

    typedef logic [TOK_W-1:0] tok_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           grant;
    logic                 busy;
    logic [BLK_CNT_W-1:0] blk_cnt0;
    logic [BLK_CNT_W-1:0] blk_cnt1;

    lz4_token_fifo_arb_if #(.TOK_W(TOK_W), .CNT_W(CNT_W)) bus ();

    lz4_token_fifo_arb #(
        .TOK_W(TOK_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .BLK_CNT_W(BLK_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant(grant), .busy(busy),
        .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    tok_t q0[$];
    tok_t q1[$];
    tok_t exp0[$];
    tok_t exp1[$];
    int   blk_order[$];
    bit   en0 = 1'b1, en1 = 1'b1, full_force = 1'b0, drain_en = 1'b0;
    int   fill = 0;
    int   cur_owner = -1;
    int   n_acc0 = 0, n_wr = 0, cyc = 0, first_wr = -1, last_wr = -1;
    logic [BLK_CNT_W-1:0] exp_blk0 = '0, exp_blk1 = '0;
    logic [7:0] blk_id0 = '0, blk_id1 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.src0_valid      = en0 && (q0.size() > 0);
        bus.src0_din        = (q0.size() > 0) ? q0[0] : '0;
        bus.src1_valid      = en1 && (q1.size() > 0);
        bus.src1_din        = (q1.size() > 0) ? q1[0] : '0;
        bus.fifo_data_count = CNT_W'(fill);
        bus.fifo_full       = full_force || (fill >= FIFO_DEPTH);
    endtask

    // Token: {last, source, block id, index in block, random payload}.
    task automatic push_blk(input int s, input int len);
        tok_t t;
        logic [31:0] r;
        for (int i = 0; i < len; i++) begin
            r = $urandom;
            t = {(i == len - 1), s[0], (s == 0) ? blk_id0 : blk_id1, i[7:0], r[28:0]};
            if (s == 0) begin q0.push_back(t); exp0.push_back(t); end
            else        begin q1.push_back(t); exp1.push_back(t); end
        end
        if (s == 0) blk_id0++; else blk_id1++;
    endtask

    // Every FIFO write must be the next token of its source and must not break into another source's block.
    task automatic score(input tok_t t);
        int   s;
        tok_t e;
        s = int'(t[TOK_W-2]);
        if (cur_owner >= 0) chk("no_interleave", 64'(s), 64'(cur_owner));
        if (s == 0) begin
            chk("write_expected_s0", 64'(exp0.size() > 0), 64'd1);
            if (exp0.size() > 0) begin e = exp0.pop_front(); chk("token_order_s0", 64'(t), 64'(e)); end
        end else begin
            chk("write_expected_s1", 64'(exp1.size() > 0), 64'd1);
            if (exp1.size() > 0) begin e = exp1.pop_front(); chk("token_order_s1", 64'(t), 64'(e)); end
        end
        if (t[TOK_W-1]) begin
            blk_order.push_back(s);
            if (s == 0) exp_blk0++; else exp_blk1++;
            cur_owner = -1;
        end else begin
            cur_owner = s;
        end
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
    endtask

    task automatic step();
        bit   a0, a1, w;
        tok_t d;
        @(negedge clk);
        a0 = bus.src0_valid && bus.src0_ready;
        a1 = bus.src1_valid && bus.src1_ready;
        w  = bus.fifo_wr_en;
        d  = bus.fifo_din;
        @(posedge clk);
        cyc++;
        #1;
        if (w) begin score(d); fill++; end
        if (drain_en && fill > 0 && $urandom_range(0, 2) == 0) fill--;
        if (a0) begin void'(q0.pop_front()); n_acc0++; end
        if (a1) void'(q1.pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); blk_order.delete();
        cur_owner = -1; fill = 0; exp_blk0 = '0; exp_blk1 = '0;
        n_wr = 0; first_wr = -1; last_wr = -1;
        full_force = 1'b0; drain_en = 1'b0; en0 = 1'b1; en1 = 1'b1;
        rst = 1'b0;
        drive();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !busy && exp0.size() == 0 && exp1.size() == 0)
               && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        int   base;
        tok_t held;

        // Reset state, with source 0 already presenting a block.
        rst = 1'b1;
        push_blk(0, 3);
        drive();
        step();
        step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("rst_din", 64'(bus.fifo_din), 64'd0);
        chk("rst_blk_cnt0", 64'(blk_cnt0), 64'd0);
        chk("rst_blk_cnt1", 64'(blk_cnt1), 64'd0);
        chk("rst_ready0", 64'(bus.src0_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_no_accept", 64'(q0.size()), 64'd3);

        // Single 3-token block from source 0.
        rst = 1'b0;
        drive();
        step();
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_bubble", 64'(bus.fifo_wr_en), 64'd0);
        chk("t1_ready0", 64'(bus.src0_ready), 64'd1);
        step();
        chk("t1_wr1", 64'(bus.fifo_wr_en), 64'd1);
        step();
        chk("t1_wr2", 64'(bus.fifo_wr_en), 64'd1);
        step();
        chk("t1_wr3", 64'(bus.fifo_wr_en), 64'd1);
        chk("t1_grant_idle", 64'(grant), 64'd0);
        step();
        chk("t1_wr_done", 64'(bus.fifo_wr_en), 64'd0);
        chk("t1_blk_cnt0", 64'(blk_cnt0), 64'd1);
        chk("t1_blk_cnt1", 64'(blk_cnt1), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_all_written", 64'(exp0.size()), 64'd0);

        // Both sources, two 4-token blocks each: alternating, back to back.
        do_reset();
        push_blk(0, 4); push_blk(1, 4); push_blk(0, 4); push_blk(1, 4);
        drive();
        wait_done(200, "t2_done");
        chk("t2_nblocks", 64'(blk_order.size()), 64'd4);
        for (int i = 0; i < 4 && i < blk_order.size(); i++)
            chk("t2_order", 64'(blk_order[i]), 64'(i % 2));
        chk("t2_nwr", 64'(n_wr), 64'd16);
        chk("t2_no_gap", 64'(last_wr - first_wr + 1), 64'd16);
        chk("t2_blk_cnt0", 64'(blk_cnt0), 64'd2);
        chk("t2_blk_cnt1", 64'(blk_cnt1), 64'd2);

        // Near-full: occupancy 509 with one write in flight allows exactly one more accept.
        do_reset();
        push_blk(0, 12);
        drive();
        step(); step(); step();
        fill = 509;
        drive();
        #1;
        chk("t3_ready_at_509", 64'(bus.src0_ready), 64'd1);
        base = n_acc0;
        step();
        chk("t3_ready_drop", 64'(bus.src0_ready), 64'd0);
        step();
        step();
        chk("t3_one_more_accept", 64'(n_acc0 - base), 64'd1);
        chk("t3_ready_held_low", 64'(bus.src0_ready), 64'd0);
        chk("t3_wr_stops", 64'(bus.fifo_wr_en), 64'd0);
        fill = 400;
        drive();
        wait_done(200, "t3_done");
        chk("t3_nwr", 64'(n_wr), 64'd12);
        chk("t3_blk_cnt0", 64'(blk_cnt0), 64'd1);

        // FIFO full while source 1 owns: writes stop, held token written once on release.
        do_reset();
        push_blk(1, 5);
        drive();
        step();
        chk("t4_grant", 64'(grant), 64'd2);
        step();
        full_force = 1'b1;
        drive();
        #1;
        chk("t4_ready_full", 64'(bus.src1_ready), 64'd0);
        step();
        chk("t4_wr_off", 64'(bus.fifo_wr_en), 64'd0);
        step(); step();
        chk("t4_wr_still_off", 64'(bus.fifo_wr_en), 64'd0);
        chk("t4_grant_kept", 64'(grant), 64'd2);
        held = q1[0];
        full_force = 1'b0;
        drive();
        step();
        chk("t4_held_wr", 64'(bus.fifo_wr_en), 64'd1);
        chk("t4_held_din", 64'(bus.fifo_din), 64'(held));
        wait_done(200, "t4_done");
        chk("t4_nwr", 64'(n_wr), 64'd5);
        chk("t4_blk_cnt1", 64'(blk_cnt1), 64'd1);

        // Owner stalls mid-block: no preemption by the other source.
        do_reset();
        push_blk(1, 6);
        drive();
        step(); step(); step();
        en1 = 1'b0;
        push_blk(0, 3);
        drive();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_grant_held", 64'(grant), 64'd2);
            chk("t5_ready0_low", 64'(bus.src0_ready), 64'd0);
        end
        en1 = 1'b1;
        drive();
        wait_done(200, "t5_done");
        chk("t5_nblocks", 64'(blk_order.size()), 64'd2);
        if (blk_order.size() == 2) begin
            chk("t5_order0", 64'(blk_order[0]), 64'd1);
            chk("t5_order1", 64'(blk_order[1]), 64'd0);
        end
        chk("t5_nwr", 64'(n_wr), 64'd9);

        // Single-token block, direct handover, then reset in the middle of a source 1 block.
        do_reset();
        push_blk(0, 1);
        push_blk(1, 6);
        drive();
        step();
        chk("t6_grant0", 64'(grant), 64'd1);
        step();
        chk("t6_no_bubble", 64'(grant), 64'd2);
        chk("t6_single_wr", 64'(bus.fifo_wr_en), 64'd1);
        step(); step();
        rst = 1'b1;
        drive();
        step();
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("t6_rst_blk_cnt0", 64'(blk_cnt0), 64'd0);
        chk("t6_rst_blk_cnt1", 64'(blk_cnt1), 64'd0);
        do_reset();
        push_blk(0, 2);
        push_blk(1, 2);
        drive();
        step();
        chk("t6_rr_after_rst", 64'(grant), 64'd1);
        wait_done(100, "t6_done");
        if (blk_order.size() > 0) chk("t6_first_block", 64'(blk_order[0]), 64'd0);

        // Randomized soak: random block lengths, valid gaps, full pulses and FIFO drain.
        do_reset();
        drain_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0) push_blk(0, int'($urandom_range(1, 6)));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0) push_blk(1, int'($urandom_range(1, 6)));
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
            full_force = ($urandom_range(0, 9) == 0);
            drive();
            step();
        end
        en0 = 1'b1;
        en1 = 1'b1;
        full_force = 1'b0;
        drive();
        wait_done(3000, "rand_done");
        chk("rand_blk_cnt0", 64'(blk_cnt0), 64'(exp_blk0));
        chk("rand_blk_cnt1", 64'(blk_cnt1), 64'(exp_blk1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
